serial_gate_sequencer: RTL



---
 rtl/serial_gate_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_gate_sequencer.sv
// Bit-serial logic unit: one NAND-built two-input gate cell stepped LSB-first
// across a WIDTH-bit operand pair under a start/busy/done handshake.

module nand2_cell (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = ~(x & y);
endmodule

module gate_cell (
   input  logic       x,
   input  logic       y,
   input  logic [2:0] op,
   output logic       z
);
   logic n_xy, n_xx, n_yy, n_x_nxy, n_y_nxy;
   logic and_o, or_o, nor_o, xor_o, xnor_o;

   // Every function below is composed purely from two-input NAND cells.
   nand2_cell u_nxy  (.x(x),       .y(y),       .z(n_xy));
   nand2_cell u_nxx  (.x(x),       .y(x),       .z(n_xx));
   nand2_cell u_nyy  (.x(y),       .y(y),       .z(n_yy));
   nand2_cell u_and  (.x(n_xy),    .y(n_xy),    .z(and_o));
   nand2_cell u_or   (.x(n_xx),    .y(n_yy),    .z(or_o));
   nand2_cell u_nor  (.x(or_o),    .y(or_o),    .z(nor_o));
   nand2_cell u_xa   (.x(x),       .y(n_xy),    .z(n_x_nxy));
   nand2_cell u_xb   (.x(y),       .y(n_xy),    .z(n_y_nxy));
   nand2_cell u_xor  (.x(n_x_nxy), .y(n_y_nxy), .z(xor_o));
   nand2_cell u_xnor (.x(xor_o),   .y(xor_o),   .z(xnor_o));

   always_comb begin
      z = 1'b0;
      case (op)
         3'd0:    z = and_o;
         3'd1:    z = or_o;
         3'd2:    z = n_xx;
         3'd3:    z = nor_o;
         3'd4:    z = xor_o;
         3'd5:    z = xnor_o;
         3'd6:    z = n_xy;
         default: z = 1'b0;
      endcase
   end
endmodule

module serial_gate_sequencer #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             cell_out;

   gate_cell u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .op (op_q),
      .z  (cell_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         op_q   <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  op_q   <= op;
                  cnt    <= '0;
                  result <= '0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               result <= {cell_out, result[WIDTH-1:1]};
               // Counter holds at WIDTH-1 on the last shift rather than wrapping.
               if (cnt == CW'(WIDTH - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= (op_q == 3'd7);
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
